// File: rtl/bip_pkg.sv
// Shared definitions for the BIP control unit: opcode map, accumulator mux
// encodings, sequencer states and the decoder output bundle.
package bip_pkg;

  localparam int OPW = 5;

  localparam logic [OPW-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPW-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPW-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPW-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPW-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPW-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPW-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPW-1:0] OPC_SUBI = 5'b00111;
  localparam logic [OPW-1:0] OPC_JMP  = 5'b01000;
  localparam logic [OPW-1:0] OPC_BEQ  = 5'b01001;
  localparam logic [OPW-1:0] OPC_BNE  = 5'b01010;
  localparam logic [OPW-1:0] OPC_OUT  = 5'b01011;

  localparam logic [1:0] SELA_RAM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op;
    logic       wr_ram;
    logic       rd_ram;
    logic       is_out;
    logic       is_jmp;
    logic       is_beq;
    logic       is_bne;
    logic       is_hlt;
  } dec_t;

endpackage

// File: rtl/bip_control_unit_if.sv
// Bus between the control unit and its neighbours (program memory,
// datapath, UART TX). master = control unit side, slave = environment side.
//   start_bip, op_code, operand, acc_zero, uart_ready : into the control unit
//   addr, sel_a, sel_b, wr_acc, op, wr_ram, rd_ram,
//   wr_uart, halted, cycle_count                      : out of the control unit
interface bip_control_unit_if
  import bip_pkg::*;
#(
  parameter int AB = 11,
  parameter int OB = 11,
  parameter int CW = 16
);
  logic           start_bip;
  logic [OPW-1:0] op_code;
  logic [OB-1:0]  operand;
  logic           acc_zero;
  logic           uart_ready;
  logic [AB-1:0]  addr;
  logic [1:0]     sel_a;
  logic           sel_b;
  logic           wr_acc;
  logic           op;
  logic           wr_ram;
  logic           rd_ram;
  logic           wr_uart;
  logic           halted;
  logic [CW-1:0]  cycle_count;

  modport master (
    input  start_bip, op_code, operand, acc_zero, uart_ready,
    output addr, sel_a, sel_b, wr_acc, op, wr_ram, rd_ram, wr_uart,
           halted, cycle_count
  );

  modport slave (
    output start_bip, op_code, operand, acc_zero, uart_ready,
    input  addr, sel_a, sel_b, wr_acc, op, wr_ram, rd_ram, wr_uart,
           halted, cycle_count
  );
endinterface

// File: rtl/bip_instr_decoder.sv
// Purely combinational opcode decoder.
//   op_code : 5-bit opcode of the instruction at the current PC
//   dec     : datapath controls plus flow-control flags (is_out/jmp/beq/bne/hlt)
// Unlisted opcodes decode as NOP (everything 0).
module bip_instr_decoder
  import bip_pkg::*;
(
  input  logic [OPW-1:0] op_code,
  output dec_t           dec
);

  always_comb begin
    dec = '0;
    case (op_code)
      OPC_HLT:  dec.is_hlt = 1'b1;
      OPC_STO:  dec.wr_ram = 1'b1;
      OPC_LD: begin
        dec.sel_a  = SELA_RAM;
        dec.rd_ram = 1'b1;
        dec.wr_acc = 1'b1;
      end
      OPC_LDI: begin
        dec.sel_a  = SELA_IMM;
        dec.wr_acc = 1'b1;
      end
      OPC_ADD, OPC_SUB: begin
        dec.sel_a  = SELA_ALU;
        dec.sel_b  = 1'b0;
        dec.op     = (op_code == OPC_SUB);
        dec.rd_ram = 1'b1;
        dec.wr_acc = 1'b1;
      end
      OPC_ADDI, OPC_SUBI: begin
        dec.sel_a  = SELA_ALU;
        dec.sel_b  = 1'b1;
        dec.op     = (op_code == OPC_SUBI);
        dec.wr_acc = 1'b1;
      end
      OPC_JMP: dec.is_jmp = 1'b1;
      OPC_BEQ: dec.is_beq = 1'b1;
      OPC_BNE: dec.is_bne = 1'b1;
      OPC_OUT: begin
        dec.is_out = 1'b1;
        dec.rd_ram = 1'b1;
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/bip_control_unit.sv
// BIP control unit: program counter, instruction decode and run/halt
// sequencer. One instruction per RUN cycle; controls are combinational from
// op_code so they line up with addr, and the datapath commits on the next edge.
//   clk, rst_n : clock, async active-low reset
//   bus        : master side of bip_control_unit_if (memory/datapath/UART)
// AB = PC width, OB = operand width (OB >= AB), CW = saturating cycle counter.
module bip_control_unit
  import bip_pkg::*;
#(
  parameter int AB = 11,
  parameter int OB = 11,
  parameter int CW = 16
)(
  input  logic                 clk,
  input  logic                 rst_n,
  bip_control_unit_if.master   bus
);

  dec_t          dec;
  state_t        state_q, state_d;
  logic [AB-1:0] pc_q, pc_d, pc_inc, tgt;
  logic [CW-1:0] cc_q, cc_d;
  logic          run;

  bip_instr_decoder u_dec (
    .op_code (bus.op_code),
    .dec     (dec)
  );

  assign run    = (state_q == ST_RUN);
  assign pc_inc = pc_q + AB'(1);          // wraps modulo 2^AB
  assign tgt    = bus.operand[AB-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cc_q    <= cc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cc_d    = cc_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        // A (re)start always begins a fresh run from address 0.
        if (bus.start_bip) begin
          state_d = ST_RUN;
          pc_d    = '0;
          cc_d    = '0;
        end
      end
      ST_RUN: begin
        // Every RUN cycle counts, including UART stalls and the HLT cycle.
        if (cc_q != '1) cc_d = cc_q + CW'(1);
        pc_d = pc_inc;
        if (dec.is_hlt) begin
          state_d = ST_HALT;
          pc_d    = pc_q;
        end else if (dec.is_jmp) begin
          pc_d = tgt;
        end else if (dec.is_beq && bus.acc_zero) begin
          pc_d = tgt;
        end else if (dec.is_bne && !bus.acc_zero) begin
          pc_d = tgt;
        end else if (dec.is_out && !bus.uart_ready) begin
          // Stall on OUT until the UART takes the byte; the strobe and the
          // PC advance happen in the same cycle, so a strobe never repeats
          // on one address.
          pc_d = pc_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Controls are gated by RUN so IDLE/HALT (and reset) present all zeros.
  assign bus.addr        = pc_q;
  assign bus.sel_a       = run ? dec.sel_a  : SELA_RAM;
  assign bus.sel_b       = run & dec.sel_b;
  assign bus.wr_acc      = run & dec.wr_acc;
  assign bus.op          = run & dec.op;
  assign bus.wr_ram      = run & dec.wr_ram;
  assign bus.rd_ram      = run & dec.rd_ram;
  assign bus.wr_uart     = run & dec.is_out & bus.uart_ready;
  assign bus.halted      = (state_q == ST_HALT);
  assign bus.cycle_count = cc_q;

endmodule

// File: tb/tb_bip_control_unit.sv
module tb_bip_control_unit;
  import bip_pkg::*;

  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  always #5 clk = ~clk;

  // DUT0: default widths; DUT1: AB=4, CW=3 for wrap and saturation.
  bip_control_unit_if #(.AB(11), .OB(11), .CW(16)) if0 ();
  bip_control_unit_if #(.AB(4),  .OB(4),  .CW(3))  if1 ();

  bip_control_unit #(.AB(11), .OB(11), .CW(16)) u0 (.clk(clk), .rst_n(rst0_n), .bus(if0));
  bip_control_unit #(.AB(4),  .OB(4),  .CW(3))  u1 (.clk(clk), .rst_n(rst1_n), .bus(if1));

  // Program memories (async read at addr).
  logic [4:0]  rom0_op  [2048];
  logic [10:0] rom0_arg [2048];
  logic [4:0]  rom1_op  [16];
  logic [3:0]  rom1_arg [16];
  assign if0.op_code = rom0_op[if0.addr];
  assign if0.operand = rom0_arg[if0.addr];
  assign if1.op_code = rom1_op[if1.addr];
  assign if1.operand = rom1_arg[if1.addr];

  localparam logic [4:0] NOP = 5'b11111;

  // Observed vector: {addr[10:0], ctl[7:0], halted, cycle_count[15:0]}
  // ctl = {sel_a[1:0], sel_b, wr_acc, op, wr_ram, rd_ram, wr_uart}
  logic [35:0] q0[$], q1[$];
  string       n0[$], n1[$];
  int checks = 0, errors = 0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drv0(input logic sb, input logic az, input logic ur);
    if0.start_bip = sb; if0.acc_zero = az; if0.uart_ready = ur;
  endtask

  task automatic exp0(input logic [10:0] a, input logic [7:0] c, input logic h,
                      input logic [15:0] cc, input string nm);
    q0.push_back({a, c, h, cc}); n0.push_back(nm);
  endtask

  task automatic exp1(input logic [10:0] a, input logic [7:0] c, input logic h,
                      input logic [15:0] cc, input string nm);
    q1.push_back({a, c, h, cc}); n1.push_back(nm);
  endtask

  // Monitor: compares whatever the DUTs present against the scoreboard.
  always @(negedge clk) begin
    logic [35:0] act, exp_v;
    string nm;
    if (q0.size() > 0) begin
      exp_v = q0.pop_front(); nm = n0.pop_front();
      act = {if0.addr, if0.sel_a, if0.sel_b, if0.wr_acc, if0.op, if0.wr_ram,
             if0.rd_ram, if0.wr_uart, if0.halted, if0.cycle_count};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL dut0 %s: got addr=%0d ctl=%h halted=%b cc=%0d, want addr=%0d ctl=%h halted=%b cc=%0d",
                 nm, act[35:25], act[24:17], act[16], act[15:0],
                 exp_v[35:25], exp_v[24:17], exp_v[16], exp_v[15:0]);
      end
    end
    if (q1.size() > 0) begin
      exp_v = q1.pop_front(); nm = n1.pop_front();
      act = {7'd0, if1.addr, if1.sel_a, if1.sel_b, if1.wr_acc, if1.op, if1.wr_ram,
             if1.rd_ram, if1.wr_uart, if1.halted, 13'd0, if1.cycle_count};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL dut1 %s: got addr=%0d ctl=%h halted=%b cc=%0d, want addr=%0d ctl=%h halted=%b cc=%0d",
                 nm, act[35:25], act[24:17], act[16], act[15:0],
                 exp_v[35:25], exp_v[24:17], exp_v[16], exp_v[15:0]);
      end
    end
  end

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    drv0(0, 0, 0);
    if1.start_bip = 1'b0; if1.acc_zero = 1'b0; if1.uart_ready = 1'b0;
    for (int i = 0; i < 2048; i++) begin rom0_op[i] = NOP; rom0_arg[i] = '0; end
    for (int i = 0; i < 16; i++) begin rom1_op[i] = NOP; rom1_arg[i] = '0; end
    rom0_op[0] = OPC_LDI; rom0_arg[0] = 11'd5;
    rom0_op[1] = OPC_ADDI; rom0_arg[1] = 11'd3;
    rom0_op[2] = OPC_STO; rom0_arg[2] = 11'd2;
    rom0_op[3] = OPC_HLT;

    // Reset and idle: outputs gated even though addr 0 holds LDI.
    tick(); exp0(0, 8'h00, 0, 0, "reset"); exp1(0, 8'h00, 0, 0, "reset");
    tick(); rst0_n = 1'b1; rst1_n = 1'b1; exp0(0, 8'h00, 0, 0, "idle");

    // Phase 1: LDI 5, ADDI 3, STO 2, HLT.
    tick(); drv0(1, 0, 0); exp0(0, 8'h00, 0, 0, "p1_start_in_idle");
    tick(); drv0(0, 0, 0); exp0(0, 8'h50, 0, 0, "p1_ldi");
    tick(); drv0(1, 0, 0); exp0(1, 8'hB0, 0, 1, "p1_addi_start_ignored");
    tick(); drv0(0, 0, 0); exp0(2, 8'h04, 0, 2, "p1_sto");
    tick(); exp0(3, 8'h00, 0, 3, "p1_hlt");
    tick(); exp0(3, 8'h00, 1, 4, "p1_halted");
    tick(); exp0(3, 8'h00, 1, 4, "p1_halt_hold");

    // Phase 2: restart from HALT; jumps, branches, ALU ops, OUT stall.
    tick();
    for (int i = 0; i < 2048; i++) begin rom0_op[i] = NOP; rom0_arg[i] = '0; end
    rom0_op[0]  = OPC_JMP;  rom0_arg[0]  = 11'd4;
    rom0_op[4]  = OPC_JMP;  rom0_arg[4]  = 11'd10;
    rom0_op[10] = OPC_BEQ;  rom0_arg[10] = 11'd20;
    rom0_op[20] = OPC_BNE;  rom0_arg[20] = 11'd30;
    rom0_op[21] = OPC_BNE;  rom0_arg[21] = 11'd30;
    rom0_op[30] = OPC_BEQ;  rom0_arg[30] = 11'd40;
    rom0_op[31] = OPC_ADD;
    rom0_op[32] = OPC_SUB;
    rom0_op[33] = OPC_SUBI;
    rom0_op[34] = OPC_LD;
    rom0_op[35] = OPC_JMP;  rom0_arg[35] = 11'd7;
    rom0_op[7]  = OPC_OUT;
    rom0_op[8]  = OPC_HLT;
    drv0(1, 0, 0); exp0(3, 8'h00, 1, 4, "p2_restart_req");
    tick(); drv0(0, 0, 0); exp0(0,  8'h00, 0, 0, "p2_restart_clears");
    tick(); exp0(4,  8'h00, 0, 1, "p2_jmp_to_4");
    tick(); drv0(0, 1, 0); exp0(10, 8'h00, 0, 2, "p2_jmp_to_10");
    tick(); drv0(0, 1, 0); exp0(20, 8'h00, 0, 3, "p2_beq_taken");
    tick(); drv0(0, 0, 0); exp0(21, 8'h00, 0, 4, "p2_bne_not_taken");
    tick(); drv0(0, 0, 0); exp0(30, 8'h00, 0, 5, "p2_bne_taken");
    tick(); drv0(0, 1, 0); exp0(31, 8'h92, 0, 6, "p2_beq_not_taken_add");
    tick(); exp0(32, 8'h9A, 0, 7, "p2_sub");
    tick(); exp0(33, 8'hB8, 0, 8, "p2_subi");
    tick(); drv0(0, 0, 0); exp0(34, 8'h12, 0, 9, "p2_ld");
    tick(); exp0(35, 8'h00, 0, 10, "p2_jmp_to_7");
    tick(); exp0(7,  8'h02, 0, 11, "p2_out_stall1");
    tick(); exp0(7,  8'h02, 0, 12, "p2_out_stall2");
    tick(); exp0(7,  8'h02, 0, 13, "p2_out_stall3");
    tick(); drv0(0, 0, 1); exp0(7, 8'h03, 0, 14, "p2_out_send");
    tick(); exp0(8,  8'h00, 0, 15, "p2_hlt");
    tick(); drv0(0, 0, 0); exp0(8, 8'h00, 1, 16, "p2_halted");

    // Phase 3: reset during an OUT stall.
    tick(); rom0_op[0] = OPC_OUT; drv0(1, 0, 0); exp0(8, 8'h00, 1, 16, "p3_restart_req");
    tick(); drv0(0, 0, 0); exp0(0, 8'h02, 0, 0, "p3_stall1");
    tick(); exp0(0, 8'h02, 0, 1, "p3_stall2");
    tick(); rst0_n = 1'b0; drv0(0, 0, 1); exp0(0, 8'h00, 0, 0, "p3_reset_mid_stall");
    tick(); drv0(1, 0, 1); exp0(0, 8'h00, 0, 0, "p3_start_in_reset");
    tick(); rst0_n = 1'b1; drv0(0, 0, 1); exp0(0, 8'h00, 0, 0, "p3_idle_after_reset");
    tick(); drv0(1, 0, 1); exp0(0, 8'h00, 0, 0, "p3_start");
    tick(); drv0(0, 0, 1); exp0(0, 8'h03, 0, 0, "p3_out_send");
    tick(); exp0(1, 8'h00, 0, 1, "p3_nop");

    // DUT1: NOP run wraps 15 -> 0, counter saturates at 7, HLT freezes it.
    tick(); if1.start_bip = 1'b1; exp1(0, 8'h00, 0, 0, "w_start");
    for (int i = 1; i <= 20; i++) begin
      tick(); if1.start_bip = 1'b0;
      if (i == 20) rom1_op[4] = OPC_HLT;
      exp1(11'((i - 1) % 16), 8'h00, 0, 16'((i - 1) > 7 ? 7 : (i - 1)),
           $sformatf("w_run%0d", i));
    end
    tick(); exp1(4, 8'h00, 0, 7, "w_hlt");
    tick(); exp1(4, 8'h00, 1, 7, "w_halt_frozen");
    tick(); exp1(4, 8'h00, 1, 7, "w_halt_hold");

    // Drain the scoreboard with a bounded wait.
    begin
      int waited = 0;
      while ((q0.size() > 0 || q1.size() > 0) && waited < 20) begin
        tick(); waited++;
      end
      if (q0.size() > 0 || q1.size() > 0) begin
        errors++;
        $display("FAIL drain: %0d/%0d entries left, want 0", q0.size(), q1.size());
      end
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded, want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/bip_control_unit.md
Name: bip_control_unit

Overview:
Second-generation BIP control unit: program counter, instruction decoder and run/halt sequencer in one block.
- Address width and counter width are parametrised.
- Adds jump, conditional branch and halt instructions.
- Adds a UART write handshake that stalls the PC, a start/halt state machine and a saturating cycle counter.
- Sits between program memory (async read at addr), the datapath (accumulator/ALU/data RAM) and the UART TX front end.

Parameters:
AB, 11, program address width (PC and jump target width)
OB, 11, instruction operand width (operand must satisfy OB >= AB)
CW, 16, cycle counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start_bip  in  1  start/restart request, level sampled each cycle
op_code  in  5  opcode of instruction at addr
operand  in  OB  operand of instruction at addr
acc_zero  in  1  accumulator == 0 flag from datapath
uart_ready  in  1  UART TX can accept a byte this cycle
addr  out  AB  program counter / program memory address
sel_a  out  2  accumulator mux select: 00 RAM, 01 immediate, 10 ALU
sel_b  out  1  ALU B select: 0 RAM, 1 immediate
wr_acc  out  1  accumulator write enable
op  out  1  ALU op: 0 add, 1 sub
wr_ram  out  1  data RAM write enable
rd_ram  out  1  data RAM read enable
wr_uart  out  1  UART TX write strobe
halted  out  1  core in HALT state
cycle_count  out  CW  RUN cycles since last start, saturating

Behaviour:
- Reset (rst_n=0, async): state=IDLE, addr=0, cycle_count=0, halted=0. All control outputs are 0 while in IDLE or HALT (combinational gating).
- States:
  - IDLE -> RUN when start_bip=1.
  - RUN -> HALT on HLT decode.
  - HALT -> RUN when start_bip=1.
- HALT->RUN clears addr and cycle_count to 0 on that edge.
- start_bip has no effect while in RUN.
- halted=1 exactly in HALT.
- In RUN, decode is combinational from op_code, so controls are valid in the same cycle addr is presented. The datapath commits on the next edge, giving 1 instruction per cycle.
- Opcode map (unlisted codes = NOP with controls 0, pc+1):
  - 00000 HLT: controls 0, PC held, next state HALT.
  - 00001 STO: wr_ram=1.
  - 00010 LD: sel_a=00, rd_ram=1, wr_acc=1.
  - 00011 LDI: sel_a=01, wr_acc=1.
  - 00100 ADD: sel_a=10, sel_b=0, op=0, rd_ram=1, wr_acc=1.
  - 00101 ADDI: sel_a=10, sel_b=1, op=0, wr_acc=1.
  - 00110 SUB: as ADD with op=1.
  - 00111 SUBI: as ADDI with op=1.
  - 01000 JMP: pc <= operand[AB-1:0].
  - 01001 BEQ: pc <= operand[AB-1:0] if acc_zero, else pc+1.
  - 01010 BNE: pc <= operand[AB-1:0] if !acc_zero, else pc+1.
  - 01011 OUT: wr_uart=uart_ready and rd_ram=1. pc+1 only in a cycle with uart_ready=1; otherwise PC is held (stall) with wr_uart=0.
- PC arithmetic is modulo 2^AB: pc+1 from 2^AB-1 wraps to 0 with no flag.
- acc_zero is sampled in the branch cycle only.
- cycle_count increments on every RUN cycle, stall cycles included. It saturates at 2^CW-1 and freezes in IDLE/HALT.
- wr_uart is never asserted for two consecutive cycles on the same addr.
- Reset asserted mid-stall or mid-run aborts immediately; no UART strobe is issued after rst_n falls.

Decomposition:
- Shared package bip_pkg: 5-bit opcode localparams (OPC_HLT..OPC_OUT), sel_a encodings (SELA_RAM, SELA_IMM, SELA_ALU), state encodings (ST_IDLE, ST_RUN, ST_HALT).
- Sub-module bip_instr_decoder: purely combinational opcode -> {sel_a, sel_b, wr_acc, op, wr_ram, rd_ram, is_out, is_jmp, is_beq, is_bne, is_hlt}.
- PC, state and counter logic stay in the top module.

Test Plan:
- Reset then start_bip pulse; program LDI 5, ADDI 3, STO 2, HLT -> addr sequence 0,1,2,3 then held at 3; wr_acc high on cycles 0–1, wr_ram on cycle 2; halted=1; cycle_count=4.
- JMP at addr 4 with operand 10 -> addr=10 next cycle. BEQ at 10 with acc_zero=1, operand 20 -> addr=20. BNE at 20 with acc_zero=1 -> addr=21.
- OUT at addr 7 with uart_ready low for 3 cycles then high -> addr held at 7 for 4 cycles; wr_uart high only in the 4th cycle; addr=8 after; cycle_count counts all 4.
- AB=4, sequential NOPs from addr 15 -> addr wraps to 0, no halt.
- rst_n low during an OUT stall -> addr=0, all controls 0, state IDLE; start_bip ignored until rst_n high.
- HALT then start_bip=1 -> addr=0, cycle_count=0, RUN resumes. CW=3 with a long loop -> cycle_count stays at 7.
